// File: rtl/nut_bus_pkg.sv
// nut_bus_pkg: shared frame geometry, FSM encoding and bit-time compare helpers
// for the serial instruction bus (CPU master and ROM-side logic).
`default_nettype none

package nut_bus_pkg;

    localparam int FRAME_LEN = 56;
    localparam int ADR_W     = 16;
    localparam int INST_W    = 10;
    localparam int ADR_T0    = 16;
    localparam int INST_T0   = 44;
    localparam int BT_W      = 6;

    localparam int ADR_T1    = ADR_T0 + ADR_W - 1;
    localparam int INST_T1   = INST_T0 + INST_W - 1;

    typedef enum logic [2:0] {
        IDLE_FRAME = 3'd0,
        ADDR       = 3'd1,
        WAIT       = 3'd2,
        INST       = 3'd3,
        DONE       = 3'd4
    } bus_state_e;

    function automatic logic bt_in_win(input logic [BT_W-1:0] bt, input int first, input int last);
        return (int'(bt) >= first) && (int'(bt) <= last);
    endfunction

    function automatic logic bt_in_adr_win(input logic [BT_W-1:0] bt);
        return bt_in_win(bt, ADR_T0, ADR_T1);
    endfunction

    function automatic logic bt_in_inst_win(input logic [BT_W-1:0] bt);
        return bt_in_win(bt, INST_T0, INST_T1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nut_frame_ctr.sv
// nut_frame_ctr: free-running bit-time counter with window decodes for both the
// current bit time and the one that follows the next clock edge.
`default_nettype none

module nut_frame_ctr
    import nut_bus_pkg::*;
#(
    parameter int FRAME_LEN = nut_bus_pkg::FRAME_LEN,
    parameter int ADR_T0    = nut_bus_pkg::ADR_T0,
    parameter int ADR_W     = nut_bus_pkg::ADR_W,
    parameter int INST_T0   = nut_bus_pkg::INST_T0,
    parameter int INST_W    = nut_bus_pkg::INST_W
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [BT_W-1:0] t,
    output logic [BT_W-1:0] t_nxt,
    output logic            t_last,
    output logic            in_adr_win,
    output logic            in_inst_win,
    output logic            adr_win_nxt,
    output logic            inst_win_nxt
);

    localparam int ADR_END  = ADR_T0 + ADR_W - 1;
    localparam int INST_END = INST_T0 + INST_W - 1;

    assign t_last = (t == BT_W'(FRAME_LEN - 1));
    assign t_nxt  = t_last ? '0 : t + BT_W'(1);

    assign in_adr_win   = bt_in_win(t, ADR_T0, ADR_END);
    assign in_inst_win  = bt_in_win(t, INST_T0, INST_END);
    // Lookahead decodes let registered bus outputs line up with the bit time.
    assign adr_win_nxt  = bt_in_win(t_nxt, ADR_T0, ADR_END);
    assign inst_win_nxt = bt_in_win(t_nxt, INST_T0, INST_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t <= '0;
        end else begin
            t <= t_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/nut_bus_master.sv
// nut_bus_master: runs the 56-bit-time frame, serialises the fetch address on ia
// and deserialises the returned instruction from is, one fetch per frame.
`default_nettype none

module nut_bus_master
    import nut_bus_pkg::*;
#(
    parameter int FRAME_LEN = nut_bus_pkg::FRAME_LEN,
    parameter int ADR_W     = nut_bus_pkg::ADR_W,
    parameter int INST_W    = nut_bus_pkg::INST_W,
    parameter int ADR_T0    = nut_bus_pkg::ADR_T0,
    parameter int INST_T0   = nut_bus_pkg::INST_T0
) (
    input  logic              cph1,
    input  logic              pon_n,
    input  logic              fetch_req,
    input  logic [ADR_W-1:0]  fetch_adr,
    output logic              fetch_ack,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic              sync,
    output logic              ia,
    input  logic              is,
    output logic [BT_W-1:0]   bit_time
);

    logic [BT_W-1:0]   t;
    logic [BT_W-1:0]   t_nxt;
    logic              t_last;
    logic              in_adr_win;
    logic              in_inst_win;
    logic              adr_win_nxt;
    logic              inst_win_nxt;

    bus_state_e        state;
    bus_state_e        state_nxt;
    logic [ADR_W-1:0]  adr_sh;
    logic [INST_W-1:0] inst_sh;

    logic              ack_d;
    logic              ia_d;
    logic              valid_d;
    logic              shift_adr;
    logic              sample_is;

    nut_frame_ctr #(
        .FRAME_LEN (FRAME_LEN),
        .ADR_T0    (ADR_T0),
        .ADR_W     (ADR_W),
        .INST_T0   (INST_T0),
        .INST_W    (INST_W)
    ) u_frame_ctr (
        .clk          (cph1),
        .rst_n        (pon_n),
        .t            (t),
        .t_nxt        (t_nxt),
        .t_last       (t_last),
        .in_adr_win   (in_adr_win),
        .in_inst_win  (in_inst_win),
        .adr_win_nxt  (adr_win_nxt),
        .inst_win_nxt (inst_win_nxt)
    );

    assign bit_time = t;

    always_ff @(posedge cph1 or negedge pon_n) begin
        if (!pon_n) begin
            state <= IDLE_FRAME;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are computed one bit time ahead and registered, so the bus pins
    // carry the value belonging to the bit time shown on bit_time.
    always_comb begin
        state_nxt = state;
        ack_d     = t_last && fetch_req;
        shift_adr = (state == ADDR) && adr_win_nxt;
        ia_d      = shift_adr && adr_sh[0];
        sample_is = (state == INST) && in_inst_win;
        valid_d   = (state == DONE) && (t_nxt == BT_W'(FRAME_LEN - 1));
        case (state)
            IDLE_FRAME: if (t_last) state_nxt = fetch_req ? ADDR : IDLE_FRAME;
            ADDR:       if (in_adr_win && !adr_win_nxt) state_nxt = WAIT;
            WAIT:       if (inst_win_nxt) state_nxt = INST;
            INST:       if (in_inst_win && !inst_win_nxt) state_nxt = DONE;
            DONE:       if (t_last) state_nxt = fetch_req ? ADDR : IDLE_FRAME;
            default:    state_nxt = IDLE_FRAME;
        endcase
    end

    always_ff @(posedge cph1 or negedge pon_n) begin
        if (!pon_n) begin
            adr_sh     <= '0;
            inst_sh    <= '0;
            inst       <= '0;
            fetch_ack  <= 1'b0;
            inst_valid <= 1'b0;
            sync       <= 1'b0;
            ia         <= 1'b0;
        end else begin
            fetch_ack  <= ack_d;
            inst_valid <= valid_d;
            sync       <= inst_win_nxt;
            ia         <= ia_d;
            if (ack_d) begin
                adr_sh <= fetch_adr;
            end else if (shift_adr) begin
                adr_sh <= adr_sh >> 1;
            end
            if (sample_is) begin
                inst_sh <= {is, inst_sh[INST_W-1:1]};
            end
            if (valid_d) begin
                inst <= inst_sh;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nut_bus_master.sv
// tb_nut_bus_master: directed vector table plus randomized frames checked
// against a frame-level reference model of the serial bus master.
`default_nettype none

module tb_nut_bus_master;

    logic        cph1;
    logic        pon_n;
    logic        fetch_req;
    logic [15:0] fetch_adr;
    logic        fetch_ack;
    logic        inst_valid;
    logic [9:0]  inst;
    logic        sync;
    logic        ia;
    logic        is;
    logic [5:0]  bit_time;

    nut_bus_master dut (
        .cph1       (cph1),
        .pon_n      (pon_n),
        .fetch_req  (fetch_req),
        .fetch_adr  (fetch_adr),
        .fetch_ack  (fetch_ack),
        .inst_valid (inst_valid),
        .inst       (inst),
        .sync       (sync),
        .ia         (ia),
        .is         (is),
        .bit_time   (bit_time)
    );

    initial cph1 = 1'b0;
    always #5 cph1 = ~cph1;

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level reference model state.
    int          m_bt;
    bit          m_busy;
    logic [15:0] m_adr;
    logic [9:0]  m_bits;
    logic [9:0]  m_inst;

    // Stimulus knobs applied by step().
    bit          g_rand;
    logic        g_req;
    logic [15:0] g_adr;
    logic [9:0]  g_is;

    // Per-frame captures used by the vector table.
    logic [15:0] cap_ia;
    logic        cap_ack;
    int          sync_cnt;
    int          valid_cnt;

    typedef struct {
        logic [15:0] adr;
        logic [9:0]  isw;
        logic [15:0] exp_ia;
        logic [9:0]  exp_inst;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bt   = 0;
        m_busy = 0;
        m_adr  = '0;
        m_bits = '0;
        m_inst = '0;
    endtask

    // One bit time: compare against the model, drive inputs, advance model and clock.
    task automatic step();
        bit in_a, in_i;
        in_a = (m_bt >= 16) && (m_bt <= 31);
        in_i = (m_bt >= 44) && (m_bt <= 53);
        if (m_bt == 55 && m_busy) m_inst = m_bits;
        chk("bit_time",   32'(bit_time),   32'(m_bt));
        chk("fetch_ack",  32'(fetch_ack),  32'(m_busy && m_bt == 0));
        chk("ia",         32'(ia),         32'((m_busy && in_a) ? m_adr[m_bt-16] : 1'b0));
        chk("sync",       32'(sync),       32'(in_i));
        chk("inst_valid", 32'(inst_valid), 32'(m_busy && m_bt == 55));
        chk("inst",       32'(inst),       32'(m_inst));
        if (in_a) cap_ia[m_bt-16] = ia;
        if (m_bt == 0) cap_ack = fetch_ack;
        if (sync === 1'b1) sync_cnt++;
        if (inst_valid === 1'b1) valid_cnt++;
        if (g_rand) begin
            g_req = 1'($urandom_range(0, 1));
            g_adr = 16'($urandom);
            g_is  = 10'($urandom);
        end
        fetch_req = g_req;
        fetch_adr = g_adr;
        is        = in_i ? g_is[m_bt-44] : 1'($urandom_range(0, 1));
        if (m_busy && in_i) m_bits[m_bt-44] = is;
        if (m_bt == 55) begin
            m_busy = fetch_req;
            m_adr  = fetch_adr;
        end
        m_bt = (m_bt == 55) ? 0 : m_bt + 1;
        @(posedge cph1);
        #1;
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_bit_time"},   32'(bit_time),   32'd0);
        chk({tag, "_sync"},       32'(sync),       32'd0);
        chk({tag, "_ia"},         32'(ia),         32'd0);
        chk({tag, "_fetch_ack"},  32'(fetch_ack),  32'd0);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_inst"},       32'(inst),       32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        tbl[0] = '{adr: 16'hA5C3, isw: 10'h2B5, exp_ia: 16'b1010_0101_1100_0011, exp_inst: 10'h2B5};
        tbl[1] = '{adr: 16'h0000, isw: 10'h3FF, exp_ia: 16'b0000_0000_0000_0000, exp_inst: 10'h3FF};
        tbl[2] = '{adr: 16'hFFFF, isw: 10'h000, exp_ia: 16'b1111_1111_1111_1111, exp_inst: 10'h000};
        tbl[3] = '{adr: 16'h0001, isw: 10'h155, exp_ia: 16'b0000_0000_0000_0001, exp_inst: 10'h155};

        g_rand = 0; g_req = 0; g_adr = '0; g_is = '0;
        fetch_req = 0; fetch_adr = '0; is = 0;
        pon_n = 0;
        model_reset();
        repeat (3) @(posedge cph1);
        #1;
        chk_all_reset("reset");
        pon_n = 1;

        // Two idle frames: sync for T44..T53 only, no fetch activity.
        sync_cnt = 0; valid_cnt = 0;
        repeat (112) step();
        chk("idle_sync_cycles", 32'(sync_cnt), 32'd20);
        chk("idle_valid_cnt",   32'(valid_cnt), 32'd0);

        // Back-to-back fetches from the vector table, fetch_req held high.
        repeat (55) step();
        for (int i = 0; i < 4; i++) begin
            g_adr = tbl[i].adr;
            g_req = 1;
            g_is  = tbl[i].isw;
            step();
            repeat (55) step();
            chk($sformatf("vec%0d_ack", i),        32'(cap_ack),    32'd1);
            chk($sformatf("vec%0d_ia_bits", i),    32'(cap_ia),     32'(tbl[i].exp_ia));
            chk($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'd1);
            chk($sformatf("vec%0d_inst", i),       32'(inst),       32'(tbl[i].exp_inst));
        end
        g_req = 0;
        step();

        // Request raised mid-frame at T20: ignored until the next T0.
        repeat (20) step();
        g_req = 1;
        g_adr = 16'h3C5A;
        g_is  = 10'h1A7;
        acks  = 0;
        for (int k = 0; k < 60 && m_bt != 0; k++) begin
            if (fetch_ack === 1'b1) acks++;
            step();
        end
        chk("late_req_early_acks", 32'(acks),      32'd0);
        chk("late_req_ack_at_t0",  32'(fetch_ack), 32'd1);
        g_req = 0;
        repeat (56) step();
        chk("late_req_inst", 32'(inst), 32'h1A7);

        // Reset asserted at T48 of a busy frame.
        repeat (55) step();
        g_req = 1; g_adr = 16'h1234; g_is = 10'h0F0;
        step();
        g_req = 0;
        repeat (48) step();
        chk("pre_reset_sync", 32'(sync), 32'd1);
        #2;
        pon_n = 0;
        #1;
        chk_all_reset("midreset");
        @(posedge cph1);
        @(posedge cph1);
        #1;
        pon_n = 1;
        model_reset();
        valid_cnt = 0;
        repeat (112) step();
        chk("post_reset_valid_cnt", 32'(valid_cnt), 32'd0);

        // Randomized frames against the model.
        g_rand = 1;
        repeat (30 * 56) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
